// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the pipelined adder/subtractor.
//   - ALU_OP_ADD / ALU_OP_SUB : encoding of the 'sub' operation select bit.
//   - chunk_w()  : chunk width handled by one pipeline stage.
//   - skew_off() : bit offset of stage k's operand skew field inside the
//                  flat skew vector (stage k keeps chunks k+1..STAGES-1).
//   - sum_off()  : bit offset of stage k's partial-result field inside the
//                  flat delay vector (stage k keeps chunks 0..k).
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Stage j keeps (width - (j+1)*cw) operand bits; sum those for j < k.
    function automatic int skew_off(input int width, input int cw, input int k);
        return k * width - (cw * k * (k + 1)) / 2;
    endfunction

    // Stage j keeps (j+1)*cw result bits; sum those for j < k.
    function automatic int sum_off(input int cw, input int k);
        return (cw * k * (k + 1)) / 2;
    endfunction

endpackage

// File: rtl/add_slice.sv
// ----------------------------------------------------------------------------
// add_slice
//   CW-bit ripple-carry adder built from full-adder cells.
//   Ports:
//     a, b      in  CW  addends
//     ci        in  1   carry into bit 0
//     s         out CW  sum
//     co        out 1   carry out of bit CW-1
//     c_msb_in  out 1   carry into bit CW-1 (used for signed overflow)
// ----------------------------------------------------------------------------
module add_slice #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co,
    output logic          c_msb_in
);

    logic [CW:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < CW; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co       = c[CW];
    assign c_msb_in = c[CW-1];

endmodule

// File: rtl/pipe_addsub.sv
// ----------------------------------------------------------------------------
// pipe_addsub
//   Pipelined carry-chain adder/subtractor. WIDTH-bit operands are split into
//   STAGES chunks of CW = WIDTH/STAGES bits; stage k adds chunk k and registers
//   its carry for stage k+1. Upper operand chunks ride along in skew registers,
//   finished lower result chunks ride along in delay registers.
//   Whole-pipe valid/ready: adv = !out_valid | out_ready, no bubble squeezing.
//
//   Ports:
//     clock      in   1      rising-edge clock
//     reset      in   1      asynchronous active-high, clears all state
//     flush      in   1      synchronous kill of all in-flight operations
//     in_valid   in   1      new operation present on a/b/ci/sub
//     in_ready   out  1      operation accepted this cycle (0 while flush)
//     a, b       in   WIDTH  operands
//     ci         in   1      carry / borrow in
//     sub        in   1      0: a+b+ci, 1: a-b-ci (a + ~b + !ci)
//     sat        in   1      clamp on signed overflow (PIPE_ADDSUB_SAT_EN only)
//     out_valid  out  1      result registers hold a valid result
//     out_ready  in   1      consumer takes the result this cycle
//     sum        out  WIDTH  result
//     co         out  1      carry out of MSB (sub: 1 = no borrow)
//     ovf        out  1      signed overflow of the unclamped result
//     zero       out  1      sum == 0 (after clamping)
//
//   Build option: define PIPE_ADDSUB_SAT_EN to add the 'sat' port and the
//   saturating result path; otherwise results always wrap.
// ----------------------------------------------------------------------------
module pipe_addsub
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
`ifdef PIPE_ADDSUB_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int CW        = chunk_w(WIDTH, STAGES);
    localparam int SKEW_BITS = skew_off(WIDTH, CW, STAGES);
    // A single stage needs no skew; the vector is kept at least one bit wide.
    localparam int SKEW_N    = (SKEW_BITS > 0) ? SKEW_BITS : 1;
    localparam int SUM_BITS  = sum_off(CW, STAGES);
    localparam int SUM_LAST  = sum_off(CW, STAGES - 1);

    // Pipeline state
    logic [STAGES-1:0]   vld_q,      vld_d;
    logic [STAGES-1:0]   carry_q,    carry_d;
    logic [SKEW_N-1:0]   a_skew_q,   a_skew_d;
    logic [SKEW_N-1:0]   b_skew_q,   b_skew_d;
    logic [SUM_BITS-1:0] sum_part_q, sum_part_d;
    logic                ovf_q,      ovf_d;
`ifdef PIPE_ADDSUB_SAT_EN
    logic [STAGES-1:0]   sat_q,      sat_d;
`endif

    // Slice interconnect
    logic [CW-1:0]     sl_a [STAGES];
    logic [CW-1:0]     sl_b [STAGES];
    logic [CW-1:0]     sl_s [STAGES];
    logic [STAGES-1:0] sl_ci;
    logic [STAGES-1:0] sl_co;
    logic              cmsb;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum_raw;
    logic             adv;
    logic             accept;

`ifdef PIPE_ADDSUB_SAT_EN
    // Clamp toward the overflow direction: a wrapped result with MSB set came
    // from a positive overflow, MSB clear from a negative overflow.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                   input logic             clamp);
        logic [WIDTH-1:0] r;
        r = raw;
        if (clamp) begin
            r = raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        end
        return r;
    endfunction
`endif

    // Handshake and output flags
    always_comb begin
        out_valid = vld_q[STAGES-1];
        adv       = !out_valid || out_ready;
        in_ready  = adv && !flush;
        accept    = in_valid && in_ready;
        b_eff     = (sub == ALU_OP_ADD) ? b : ~b;
        sum_raw   = sum_part_q[SUM_LAST +: WIDTH];
`ifdef PIPE_ADDSUB_SAT_EN
        sum       = saturate(sum_raw, sat_q[STAGES-1] && ovf_q);
`else
        sum       = sum_raw;
`endif
        zero      = ~|sum;
        co        = carry_q[STAGES-1];
        ovf       = ovf_q;
    end

    // Slice inputs: stage 0 takes the live operands, later stages take the
    // lowest chunk still waiting in the previous stage's skew field.
    always_comb begin
        sl_a[0]  = a[CW-1:0];
        sl_b[0]  = b_eff[CW-1:0];
        sl_ci[0] = ci ^ (sub == ALU_OP_SUB);
        for (int k = 1; k < STAGES; k++) begin
            sl_a[k]  = a_skew_q[skew_off(WIDTH, CW, k - 1) +: CW];
            sl_b[k]  = b_skew_q[skew_off(WIDTH, CW, k - 1) +: CW];
            sl_ci[k] = carry_q[k - 1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        if (k == STAGES - 1) begin : g_last
            add_slice #(.CW(CW)) u_slice (
                .a        (sl_a[k]),
                .b        (sl_b[k]),
                .ci       (sl_ci[k]),
                .s        (sl_s[k]),
                .co       (sl_co[k]),
                .c_msb_in (cmsb)
            );
        end else begin : g_mid
            add_slice #(.CW(CW)) u_slice (
                .a        (sl_a[k]),
                .b        (sl_b[k]),
                .ci       (sl_ci[k]),
                .s        (sl_s[k]),
                .co       (sl_co[k]),
                .c_msb_in ()
            );
        end
    end

    // Next-state of every stage
    always_comb begin
        vld_d      = '0;
        a_skew_d   = '0;
        b_skew_d   = '0;
        sum_part_d = '0;
        carry_d    = sl_co;
        ovf_d      = cmsb ^ sl_co[STAGES-1];

        vld_d[0] = accept;
        for (int k = 1; k < STAGES; k++) begin
            vld_d[k] = vld_q[k - 1];
        end

        // Stage 0: first result chunk, chunks 1.. of the operands go to skew
        sum_part_d[CW-1:0] = sl_s[0];
        for (int j = 1; j < STAGES; j++) begin
            a_skew_d[(j - 1) * CW +: CW] = a[j * CW +: CW];
            b_skew_d[(j - 1) * CW +: CW] = b_eff[j * CW +: CW];
        end

        // Stage k: append its chunk above the delayed lower chunks, shift skew
        for (int k = 1; k < STAGES; k++) begin
            for (int j = 0; j < k; j++) begin
                sum_part_d[sum_off(CW, k) + j * CW +: CW] =
                    sum_part_q[sum_off(CW, k - 1) + j * CW +: CW];
            end
            sum_part_d[sum_off(CW, k) + k * CW +: CW] = sl_s[k];
            for (int j = k + 1; j < STAGES; j++) begin
                a_skew_d[skew_off(WIDTH, CW, k) + (j - k - 1) * CW +: CW] =
                    a_skew_q[skew_off(WIDTH, CW, k - 1) + (j - k) * CW +: CW];
                b_skew_d[skew_off(WIDTH, CW, k) + (j - k - 1) * CW +: CW] =
                    b_skew_q[skew_off(WIDTH, CW, k - 1) + (j - k) * CW +: CW];
            end
        end

`ifdef PIPE_ADDSUB_SAT_EN
        sat_d    = '0;
        sat_d[0] = sat;
        for (int k = 1; k < STAGES; k++) begin
            sat_d[k] = sat_q[k - 1];
        end
`endif
    end

    // Stage boundary: all stages advance together on adv; flush only kills valids
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q      <= '0;
            carry_q    <= '0;
            a_skew_q   <= '0;
            b_skew_q   <= '0;
            sum_part_q <= '0;
            ovf_q      <= 1'b0;
`ifdef PIPE_ADDSUB_SAT_EN
            sat_q      <= '0;
`endif
        end else begin
            if (flush) begin
                vld_q <= '0;
            end else if (adv) begin
                vld_q <= vld_d;
            end
            if (adv) begin
                carry_q    <= carry_d;
                a_skew_q   <= a_skew_d;
                b_skew_q   <= b_skew_d;
                sum_part_q <= sum_part_d;
                ovf_q      <= ovf_d;
`ifdef PIPE_ADDSUB_SAT_EN
                sat_q      <= sat_d;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pipe_addsub.sv
// ----------------------------------------------------------------------------
// tb_pipe_addsub
//   Directed bench for pipe_addsub (WIDTH=32, STAGES=4). A queue-based model
//   computes each accepted operation's result with plain wide arithmetic; a
//   negedge monitor compares every transferred result against it. Directed
//   sequences pin literal values, latency, throughput, stall, flush and reset.
// ----------------------------------------------------------------------------
module tb_pipe_addsub;

    localparam int W = 32;
`ifdef PIPE_ADDSUB_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_r = '0;
    logic [W-1:0] b_r = '0;
    logic         ci_r = 1'b0;
    logic         sub_r = 1'b0;
    logic         sat_r = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
    logic         zero;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
        logic         zero;
    } exp_t;

    exp_t exp_q[$];

    pipe_addsub #(.WIDTH(W), .STAGES(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_r),
        .b         (b_r),
        .ci        (ci_r),
        .sub       (sub_r),
`ifdef PIPE_ADDSUB_SAT_EN
        .sat       (sat_r),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clock = ~clock;

    // Reference: whole-word arithmetic, overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mci, input logic msub, input logic msat);
        exp_t         r;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb     = msub ? ~mb : mb;
        full   = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, mci ^ msub};
        r.sum  = full[W-1:0];
        r.co   = full[W];
        r.ovf  = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
        if (SAT_EN && msat && r.ovf) begin
            r.sum = ma[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        r.zero = (r.sum == '0);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    // Monitor: the model queue follows every transfer in and out.
    always @(negedge clock) begin
        exp_t e;
        if (reset || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                check("valid_has_pending_op", 64'(exp_q.size() > 0), 64'd1);
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mon_sum",  64'(sum),  64'(e.sum));
                check("mon_co",   64'(co),   64'(e.co));
                check("mon_ovf",  64'(ovf),  64'(e.ovf));
                check("mon_zero", 64'(zero), 64'(e.zero));
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a_r, b_r, ci_r, sub_r, sat_r));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ici, input logic isub, input logic isat);
        logic ok;
        ok       = 1'b0;
        a_r      = ia;
        b_r      = ib;
        ci_r     = ici;
        sub_r    = isub;
        sat_r    = isat;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clock);
            ok = in_ready && !flush;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        check("issue_accepted", 64'(ok), 64'd1);
    endtask

    // Returns on the negedge where out_valid is first seen high.
    task automatic wait_result(input string name);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clock);
            got = out_valid;
        end
        check({name, "_arrives"}, 64'(got), 64'd1);
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] es,
                              input logic eco, input logic eovf, input logic ez);
        check({name, "_sum"},  64'(sum),  64'(es));
        check({name, "_co"},   64'(co),   64'(eco));
        check({name, "_ovf"},  64'(ovf),  64'(eovf));
        check({name, "_zero"}, 64'(zero), 64'(ez));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        expect_out("rst", 32'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;

        // Latency: result appears exactly 4 cycles after the accepting edge
        issue(32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            check("lat_early_valid", 64'(out_valid), 64'd0);
        end
        @(negedge clock);
        check("lat4_valid", 64'(out_valid), 64'd1);
        expect_out("lat4", 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;

        // Signed overflow and zero/no-borrow subtraction
        issue(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        wait_result("ovf");
        expect_out("ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        issue(32'h5, 32'h5, 1'b0, 1'b1, 1'b0);
        wait_result("sub0");
        expect_out("sub0", 32'h0, 1'b1, 1'b0, 1'b1);
        @(posedge clock);
        #1;

        // Back-to-back: 8 ops, 8 results on consecutive cycles in order
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    issue(32'h1111_1111 * i, 32'h0F0F_0F0F ^ i, i[1], i[0], 1'b0);
                end
            end
            begin
                got = 1'b0;
                for (int n = 0; n < 40 && !got; n++) begin
                    @(negedge clock);
                    got = out_valid;
                end
                check("b2b_first", 64'(got), 64'd1);
                for (int j = 1; j < 8; j++) begin
                    @(negedge clock);
                    check("b2b_consecutive", 64'(out_valid), 64'd1);
                end
            end
        join
        repeat (8) @(posedge clock);
        #1;

        // Stall: out_ready low holds result and blocks input
        out_ready = 1'b0;
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        wait_result("stall");
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_sum", 64'(sum), 64'h2345_6789);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Flush kills 3 in-flight ops and refuses a same-cycle op
        issue(32'h10, 32'h1, 1'b0, 1'b0, 1'b0);
        issue(32'h20, 32'h2, 1'b0, 1'b0, 1'b0);
        issue(32'h30, 32'h3, 1'b0, 1'b0, 1'b0);
        flush    = 1'b1;
        a_r      = 32'hDEAD_0000;
        in_valid = 1'b1;
        @(negedge clock);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("flush_killed_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clock);
        #1;
        issue(32'd100, 32'd23, 1'b1, 1'b0, 1'b0);
        wait_result("post_flush");
        expect_out("post_flush", 32'd124, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;

        // Asynchronous reset between edges, then clean recovery
        issue(32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
        issue(32'h3, 32'h4, 1'b0, 1'b0, 1'b0);
        wait_result("pre_rst");
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_sum", 64'(sum), 64'd0);
        check("arst_zero", 64'(zero), 64'd1);
        @(posedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        check("arst_release_valid", 64'(out_valid), 64'd0);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        wait_result("recover");
        expect_out("recover", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        @(posedge clock);
        #1;

`ifdef PIPE_ADDSUB_SAT_EN
        issue(32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1);
        wait_result("sat_on");
        expect_out("sat_on", 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        issue(32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b0);
        wait_result("sat_off");
        expect_out("sat_off", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        @(posedge clock);
        #1;
`endif

        repeat (8) @(posedge clock);
        @(negedge clock);
        check("drained_queue", 64'(exp_q.size()), 64'd0);
        check("drained_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
